range_reducer: RTL and testbench

- Parametrised successor to the 4-bit, 2-bit-mode index reducer.
- Accepts a WIDTH-bit random value and a runtime modulus over a valid/ready handshake.
- Computes value mod modulus by iterative compare-subtract and returns the index over a second valid/ready handshake.
- Sits between the random source and the index consumers (selection/lookup logic).

---
 rtl/range_reducer_pkg.sv | 13 +
 rtl/range_reducer_step.sv | 17 +
 rtl/range_reducer.sv | 153 +++++++++++++++
 tb/tb_range_reducer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/range_reducer_pkg.sv
// Shared types and defaults for the range reducer.
// Holds the FSM state encoding and the default data width.
package range_reducer_pkg;

   localparam int RR_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REDUCE = 2'd1,
      ST_HOLD   = 2'd2
   } rr_state_e;

endpackage

// File: rtl/range_reducer_step.sv
// One compare-and-conditional-subtract of a remainder against a divisor.
// Subtraction happens only when rem >= divisor, so it never underflows.
module range_reducer_step #(
   parameter int W = 8
) (
   input  logic [W-1:0] rem,
   input  logic [W-1:0] divisor,
   output logic         take,
   output logic [W-1:0] rem_next
);

   always_comb begin
      take     = (rem >= divisor);
      rem_next = take ? (rem - divisor) : rem;
   end

endmodule

// File: rtl/range_reducer.sv
// value mod modulus over valid/ready handshakes.
// Define RANGE_REDUCER_FAST_EN for fixed-latency restoring shift-subtract.
module range_reducer
   import range_reducer_pkg::*;
#(
   parameter int WIDTH = RR_WIDTH,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_value,
   input  logic [WIDTH-1:0] in_modulus,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_index,
   output logic             out_err,
   output logic             busy
);

   rr_state_e        state_q, state_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] mod_q, mod_d;
   logic [WIDTH-1:0] idx_q, idx_d;
   logic             err_q, err_d;
   logic             vld_q, vld_d;

`ifdef RANGE_REDUCER_FAST_EN
   logic [WIDTH-1:0] div_q, div_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             take;
   logic [WIDTH:0]   step_next;

   // partial remainder stays below mod, so one extra bit covers the shift
   range_reducer_step #(.W(WIDTH + 1)) u_step (
      .rem      ({rem_q, div_q[WIDTH-1]}),
      .divisor  ({1'b0, mod_q}),
      .take     (take),
      .rem_next (step_next)
   );
`else
   logic             take;
   logic [WIDTH-1:0] step_next;

   range_reducer_step #(.W(WIDTH)) u_step (
      .rem      (rem_q),
      .divisor  (mod_q),
      .take     (take),
      .rem_next (step_next)
   );
`endif

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      mod_d   = mod_q;
      idx_d   = idx_q;
      err_d   = err_q;
      vld_d   = vld_q;
`ifdef RANGE_REDUCER_FAST_EN
      div_d   = div_q;
      cnt_d   = cnt_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               mod_d   = in_modulus;
               state_d = ST_REDUCE;
`ifdef RANGE_REDUCER_FAST_EN
               rem_d   = '0;
               div_d   = in_value;
               cnt_d   = '0;
`else
               rem_d   = in_value;
`endif
            end
         end
         ST_REDUCE: begin
            // zero modulus still spends one cycle here: uniform 1-edge latency
            if (mod_q == '0) begin
               idx_d   = '0;
               err_d   = 1'b1;
               vld_d   = 1'b1;
               state_d = ST_HOLD;
`ifdef RANGE_REDUCER_FAST_EN
            end else if (cnt_q == CNT_W'(WIDTH)) begin
               idx_d   = rem_q;
               err_d   = 1'b0;
               vld_d   = 1'b1;
               state_d = ST_HOLD;
            end else begin
               rem_d   = step_next[WIDTH-1:0];
               div_d   = {div_q[WIDTH-2:0], 1'b0};
               cnt_d   = cnt_q + 1'b1;
            end
`else
            end else if (take) begin
               rem_d   = step_next;
            end else begin
               idx_d   = rem_q;
               err_d   = 1'b0;
               vld_d   = 1'b1;
               state_d = ST_HOLD;
            end
`endif
         end
         ST_HOLD: begin
            if (out_ready) begin
               vld_d   = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            vld_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         rem_q   <= '0;
         mod_q   <= '0;
         idx_q   <= '0;
         err_q   <= 1'b0;
         vld_q   <= 1'b0;
`ifdef RANGE_REDUCER_FAST_EN
         div_q   <= '0;
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         mod_q   <= mod_d;
         idx_q   <= idx_d;
         err_q   <= err_d;
         vld_q   <= vld_d;
`ifdef RANGE_REDUCER_FAST_EN
         div_q   <= div_d;
         cnt_q   <= cnt_d;
`endif
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE);
   assign out_valid = vld_q;
   assign out_index = idx_q;
   assign out_err   = err_q;

endmodule

// File: tb/tb_range_reducer.sv
// Directed vector bench for range_reducer.
// Covers results, latency, backpressure and mid-operation reset.
module tb_range_reducer;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_value;
   logic [W-1:0] in_modulus;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_index;
   logic         out_err;
   logic         busy;

   int checks = 0;
   int errors = 0;

   range_reducer #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_value   (in_value),
      .in_modulus (in_modulus),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_index  (out_index),
      .out_err    (out_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] v;
      logic [W-1:0] m;
      logic [W-1:0] idx;
      logic         err;
      int           lat;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int exp_lat(input int lat_default, input logic [W-1:0] m);
`ifdef RANGE_REDUCER_FAST_EN
      return (m == '0) ? 1 : W + 1;
`else
      return lat_default;
`endif
   endfunction

   // accept one operand, wait for the result, then complete the handshake
   task automatic run_op(input logic [W-1:0] v, input logic [W-1:0] m,
                         output logic [W-1:0] idx, output logic err,
                         output int lat);
      int guard;
      guard = 0;
      while (!in_ready && guard < 20) begin
         @(posedge clk); #1; guard++;
      end
      chk("in_ready_before_accept", int'(in_ready), 1);
      @(negedge clk);
      in_value   = v;
      in_modulus = m;
      in_valid   = 1'b1;
      @(posedge clk); #1;
      in_valid   = 1'b0;
      in_value   = W'($urandom);
      in_modulus = W'($urandom);
      chk("busy_after_accept", int'(busy), 1);
      lat = 0;
      do begin
         @(posedge clk); #1; lat++;
      end while (!out_valid && lat < 600);
      idx = out_index;
      err = out_err;
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   initial begin
      logic [W-1:0] idx;
      logic         err;
      int           lat;
      int           seen;

      vecs[0] = '{v: 8'd13,  m: 8'd4,   idx: 8'd1,   err: 1'b0, lat: 4};
      vecs[1] = '{v: 8'd12,  m: 8'd4,   idx: 8'd0,   err: 1'b0, lat: 4};
      vecs[2] = '{v: 8'd3,   m: 8'd4,   idx: 8'd3,   err: 1'b0, lat: 1};
      vecs[3] = '{v: 8'd200, m: 8'd0,   idx: 8'd0,   err: 1'b1, lat: 1};
      vecs[4] = '{v: 8'd7,   m: 8'd5,   idx: 8'd2,   err: 1'b0, lat: 2};
      vecs[5] = '{v: 8'd255, m: 8'd1,   idx: 8'd0,   err: 1'b0, lat: 256};
      vecs[6] = '{v: 8'd0,   m: 8'd7,   idx: 8'd0,   err: 1'b0, lat: 1};
      vecs[7] = '{v: 8'd255, m: 8'd255, idx: 8'd0,   err: 1'b0, lat: 2};
      vecs[8] = '{v: 8'd254, m: 8'd255, idx: 8'd254, err: 1'b0, lat: 1};
      vecs[9] = '{v: 8'd100, m: 8'd7,   idx: 8'd2,   err: 1'b0, lat: 15};

      rst        = 1'b1;
      in_valid   = 1'b0;
      in_value   = '0;
      in_modulus = '0;
      out_ready  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_in_ready",  int'(in_ready),  1);
      chk("reset_out_valid", int'(out_valid), 0);
      chk("reset_out_index", int'(out_index), 0);
      chk("reset_out_err",   int'(out_err),   0);
      chk("reset_busy",      int'(busy),      0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         run_op(vecs[i].v, vecs[i].m, idx, err, lat);
         chk($sformatf("vec%0d_index", i), int'(idx), int'(vecs[i].idx));
         chk($sformatf("vec%0d_err", i), int'(err), int'(vecs[i].err));
         chk($sformatf("vec%0d_latency", i), lat, exp_lat(vecs[i].lat, vecs[i].m));
         chk($sformatf("vec%0d_out_valid_clear", i), int'(out_valid), 0);
         chk($sformatf("vec%0d_in_ready_back", i), int'(in_ready), 1);
      end

      // backpressure: result held, new input ignored
      @(negedge clk);
      in_value   = 8'd13;
      in_modulus = 8'd4;
      in_valid   = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      seen = 0;
      while (!out_valid && seen < 600) begin
         @(posedge clk); #1; seen++;
      end
      chk("bp_out_valid_seen", int'(out_valid), 1);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         in_valid   = 1'b1;
         in_value   = W'(c + 40);
         in_modulus = 8'd3;
         @(posedge clk); #1;
         chk($sformatf("bp_index_c%0d", c), int'(out_index), 1);
         chk($sformatf("bp_err_c%0d", c), int'(out_err), 0);
         chk($sformatf("bp_valid_c%0d", c), int'(out_valid), 1);
         chk($sformatf("bp_in_ready_c%0d", c), int'(in_ready), 0);
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp_release_valid", int'(out_valid), 0);
      chk("bp_release_busy", int'(busy), 0);
      repeat (3) @(posedge clk);
      #1;
      chk("bp_single_handshake", int'(out_valid), 0);
      chk("bp_idle_in_ready", int'(in_ready), 1);

      // reset in the middle of a long reduction
      @(negedge clk);
      in_value   = 8'd200;
      in_modulus = 8'd3;
      in_valid   = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_mid_in_ready",  int'(in_ready),  1);
      chk("rst_mid_out_valid", int'(out_valid), 0);
      chk("rst_mid_out_index", int'(out_index), 0);
      chk("rst_mid_out_err",   int'(out_err),   0);
      chk("rst_mid_busy",      int'(busy),      0);
      @(negedge clk);
      rst  = 1'b0;
      seen = 0;
      for (int c = 0; c < 100; c++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      chk("rst_mid_no_valid", seen, 0);
      run_op(8'd10, 8'd3, idx, err, lat);
      chk("post_rst_index", int'(idx), 1);
      chk("post_rst_err", int'(err), 0);
      chk("post_rst_latency", lat, exp_lat(4, 8'd3));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
